// File: rtl/ulpb_sleep_ctrl_pkg.sv
// Shared encodings for the ULPB sleep controller: isolation levels, 4-bit sleep-state codes
// and the per-state power/clock/reset/isolation control word.
package ulpb_sleep_ctrl_pkg;

    localparam logic IO_HOLD    = 1'b1;
    localparam logic IO_RELEASE = 1'b0;

    localparam logic [3:0] SLP_SLEEP   = 4'd0;
    localparam logic [3:0] SLP_PWR_ON  = 4'd1;
    localparam logic [3:0] SLP_CLK_ON  = 4'd2;
    localparam logic [3:0] SLP_ISO_OFF = 4'd3;
    localparam logic [3:0] SLP_RST_OFF = 4'd4;
    localparam logic [3:0] SLP_ACTIVE  = 4'd5;
    localparam logic [3:0] SLP_RST_ON  = 4'd6;
    localparam logic [3:0] SLP_ISO_ON  = 4'd7;
    localparam logic [3:0] SLP_CLK_OFF = 4'd8;
    localparam logic [3:0] SLP_PWR_OFF = 4'd9;

    typedef struct packed {
        logic mbc_sleep;
        logic mbc_clk_en;
        logic mbc_resetn;
        logic iso;
    } pwr_ctrl_t;

    function automatic pwr_ctrl_t state_ctrl(input logic [3:0] s);
        pwr_ctrl_t c;
        case (s)
            SLP_PWR_ON:              c = pwr_ctrl_t'({1'b0, 1'b0, 1'b0, IO_HOLD});
            SLP_CLK_ON:              c = pwr_ctrl_t'({1'b0, 1'b1, 1'b0, IO_HOLD});
            SLP_ISO_OFF:             c = pwr_ctrl_t'({1'b0, 1'b1, 1'b0, IO_RELEASE});
            SLP_RST_OFF, SLP_ACTIVE: c = pwr_ctrl_t'({1'b0, 1'b1, 1'b1, IO_RELEASE});
            SLP_RST_ON:              c = pwr_ctrl_t'({1'b0, 1'b1, 1'b0, IO_RELEASE});
            SLP_ISO_ON:              c = pwr_ctrl_t'({1'b0, 1'b1, 1'b0, IO_HOLD});
            SLP_CLK_OFF:             c = pwr_ctrl_t'({1'b0, 1'b0, 1'b0, IO_HOLD});
            default:                 c = pwr_ctrl_t'({1'b1, 1'b0, 1'b0, IO_HOLD});
        endcase
        return c;
    endfunction

    // Successor of each transitional state; unknown codes fall back to sleep.
    function automatic logic [3:0] next_step(input logic [3:0] s);
        case (s)
            SLP_PWR_ON:  return SLP_CLK_ON;
            SLP_CLK_ON:  return SLP_ISO_OFF;
            SLP_ISO_OFF: return SLP_RST_OFF;
            SLP_RST_OFF: return SLP_ACTIVE;
            SLP_RST_ON:  return SLP_ISO_ON;
            SLP_ISO_ON:  return SLP_CLK_OFF;
            SLP_CLK_OFF: return SLP_PWR_OFF;
            default:     return SLP_SLEEP;
        endcase
    endfunction

    function automatic logic in_wake_seq(input logic [3:0] s);
        return (s >= SLP_PWR_ON) && (s <= SLP_RST_OFF);
    endfunction

    function automatic logic in_sleep_seq(input logic [3:0] s);
        return (s >= SLP_RST_ON) && (s <= SLP_PWR_OFF);
    endfunction

endpackage

// File: rtl/ulpb_step_timer.sv
// Loadable down-counter that stops at zero; done is the terminal-count compare.
module ulpb_step_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/ulpb_sleep_ctrl.sv
// Power/isolation sequencer for one ULPB layer: steps the MBC through power, clock, isolation
// and reset in a fixed order, and raises EXTERNAL_INT toward the line controller.
//
//  state       | meaning
//  S_SLEEP     | MBC power-gated, isolation held
//  S_PWR_ON    | power restored
//  S_CLK_ON    | clock enabled
//  S_ISO_OFF   | isolation released
//  S_RST_OFF   | reset released
//  S_ACTIVE    | MBC running
//  S_RST_ON    | reset asserted
//  S_ISO_ON    | isolation held
//  S_CLK_OFF   | clock gated
//  S_PWR_OFF   | power gated, returning to sleep
module ulpb_sleep_ctrl
    import ulpb_sleep_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 2,
    parameter int INT_TIMEOUT = 16
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic WAKEUP_REQ,
    input  logic SLEEP_REQ,
    input  logic EXT_INT_REQ,
    input  logic BUS_BUSY,
    output logic MBC_SLEEP,
    output logic MBC_CLK_EN,
    output logic MBC_RESETn,
    output logic RELEASE_ISO_FROM_SLEEP_CTRL,
    output logic EXTERNAL_INT,
    output logic SLEEP_STATE
);

    localparam int STEP_W  = $clog2(STEP_CYCLES + 1);
    localparam int TO_W    = (INT_TIMEOUT > 0) ? $clog2(INT_TIMEOUT + 1) : 1;
    localparam int TO_LOAD = (INT_TIMEOUT > 0) ? INT_TIMEOUT - 1 : 0;
    localparam logic TIMEOUT_EN = (INT_TIMEOUT != 0);
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LOAD_V = TO_W'(TO_LOAD);

    logic [3:0] state, state_nxt;
    logic       wake_pend, wake_pend_nxt;
    logic       sleep_pend, sleep_pend_nxt;
    logic       step_done;
    logic       wake_in;
    pwr_ctrl_t  ctrl_nxt;

    logic int_req_q, busy_q, int_armed;
    logic int_set, int_clr, to_done;

    assign wake_in = WAKEUP_REQ | EXT_INT_REQ;

    // Reloaded on every state change so each transitional state lasts STEP_CYCLES cycles.
    ulpb_step_timer #(.WIDTH(STEP_W)) u_step_timer (
        .clk      (CLK),
        .resetn   (RESETn),
        .load     (state_nxt != state),
        .load_val (STEP_LOAD),
        .en       (1'b1),
        .done     (step_done)
    );

    ulpb_step_timer #(.WIDTH(TO_W)) u_int_timer (
        .clk      (CLK),
        .resetn   (RESETn),
        .load     (int_set),
        .load_val (TO_LOAD_V),
        .en       (EXTERNAL_INT),
        .done     (to_done)
    );

    always_comb begin
        state_nxt      = state;
        wake_pend_nxt  = wake_pend;
        sleep_pend_nxt = sleep_pend;
        case (state)
            SLP_SLEEP: begin
                if (wake_in || wake_pend) begin
                    state_nxt     = SLP_PWR_ON;
                    wake_pend_nxt = 1'b0;
                end
            end
            SLP_ACTIVE: begin
                if (SLEEP_REQ || sleep_pend) begin
                    state_nxt      = SLP_RST_ON;
                    sleep_pend_nxt = 1'b0;
                    if (WAKEUP_REQ) wake_pend_nxt = 1'b1;
                end
            end
            default: begin
                // Sequences never abort; opposite requests wait in the pending flags.
                if (in_wake_seq(state) && SLEEP_REQ) sleep_pend_nxt = 1'b1;
                if (in_sleep_seq(state) && wake_in)  wake_pend_nxt  = 1'b1;
                if (step_done) state_nxt = next_step(state);
            end
        endcase
    end

    assign ctrl_nxt = state_ctrl(state_nxt);
    assign int_set  = int_req_q && int_armed && !EXTERNAL_INT;
    assign int_clr  = EXTERNAL_INT && (busy_q || (TIMEOUT_EN && to_done));

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state                       <= SLP_SLEEP;
            wake_pend                   <= 1'b0;
            sleep_pend                  <= 1'b0;
            MBC_SLEEP                   <= 1'b1;
            MBC_CLK_EN                  <= 1'b0;
            MBC_RESETn                  <= 1'b0;
            RELEASE_ISO_FROM_SLEEP_CTRL <= IO_HOLD;
            SLEEP_STATE                 <= 1'b1;
        end else begin
            state                       <= state_nxt;
            wake_pend                   <= wake_pend_nxt;
            sleep_pend                  <= sleep_pend_nxt;
            MBC_SLEEP                   <= ctrl_nxt.mbc_sleep;
            MBC_CLK_EN                  <= ctrl_nxt.mbc_clk_en;
            MBC_RESETn                  <= ctrl_nxt.mbc_resetn;
            RELEASE_ISO_FROM_SLEEP_CTRL <= ctrl_nxt.iso;
            SLEEP_STATE                 <= (state_nxt == SLP_SLEEP);
        end
    end

    // Request and bus-busy are registered so EXTERNAL_INT reacts one edge after sampling.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            int_req_q    <= 1'b0;
            busy_q       <= 1'b0;
            int_armed    <= 1'b1;
            EXTERNAL_INT <= 1'b0;
        end else begin
            int_req_q <= EXT_INT_REQ && (state != SLP_ACTIVE);
            busy_q    <= BUS_BUSY;
            if (int_set) begin
                EXTERNAL_INT <= 1'b1;
            end else if (int_clr) begin
                EXTERNAL_INT <= 1'b0;
            end
            if (!EXT_INT_REQ) begin
                int_armed <= 1'b1;
            end else if (int_set) begin
                int_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ulpb_sleep_ctrl.sv
// Scoreboard bench for ulpb_sleep_ctrl: stimulus queues cycle-tagged expected outputs,
// a negedge monitor compares them against the DUT.
module tb_ulpb_sleep_ctrl;
    import ulpb_sleep_ctrl_pkg::*;

    logic clk = 1'b0;
    logic resetn, wakeup_req, sleep_req, ext_int_req, bus_busy;
    logic mbc_sleep, mbc_clk_en, mbc_resetn, iso, ext_int, sleep_state;

    ulpb_sleep_ctrl #(.STEP_CYCLES(2), .INT_TIMEOUT(16)) dut (
        .CLK                         (clk),
        .RESETn                      (resetn),
        .WAKEUP_REQ                  (wakeup_req),
        .SLEEP_REQ                   (sleep_req),
        .EXT_INT_REQ                 (ext_int_req),
        .BUS_BUSY                    (bus_busy),
        .MBC_SLEEP                   (mbc_sleep),
        .MBC_CLK_EN                  (mbc_clk_en),
        .MBC_RESETn                  (mbc_resetn),
        .RELEASE_ISO_FROM_SLEEP_CTRL (iso),
        .EXTERNAL_INT                (ext_int),
        .SLEEP_STATE                 (sleep_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output vector: {MBC_SLEEP, MBC_CLK_EN, MBC_RESETn, ISO, EXTERNAL_INT, SLEEP_STATE}
    localparam logic H = IO_HOLD;
    localparam logic R = IO_RELEASE;
    localparam logic [5:0] V_SLEEP   = {1'b1, 1'b0, 1'b0, H, 1'b0, 1'b1};
    localparam logic [5:0] V_PWR_ON  = {1'b0, 1'b0, 1'b0, H, 1'b0, 1'b0};
    localparam logic [5:0] V_CLK_ON  = {1'b0, 1'b1, 1'b0, H, 1'b0, 1'b0};
    localparam logic [5:0] V_ISO_OFF = {1'b0, 1'b1, 1'b0, R, 1'b0, 1'b0};
    localparam logic [5:0] V_RST_OFF = {1'b0, 1'b1, 1'b1, R, 1'b0, 1'b0};
    localparam logic [5:0] V_ACTIVE  = V_RST_OFF;
    localparam logic [5:0] V_RST_ON  = {1'b0, 1'b1, 1'b0, R, 1'b0, 1'b0};
    localparam logic [5:0] V_ISO_ON  = {1'b0, 1'b1, 1'b0, H, 1'b0, 1'b0};
    localparam logic [5:0] V_CLK_OFF = {1'b0, 1'b0, 1'b0, H, 1'b0, 1'b0};
    localparam logic [5:0] V_PWR_OFF = {1'b1, 1'b0, 1'b0, H, 1'b0, 1'b0};
    localparam logic [5:0] E1 = 6'b000010;
    localparam logic [5:0] E0 = 6'b000000;
    localparam logic [5:0] MA = 6'b111111;
    localparam logic [5:0] MS = 6'b111101;
    localparam logic [5:0] ME = 6'b000010;

    typedef struct {
        int         cyc;
        logic [5:0] exp;
        logic [5:0] mask;
        string      name;
    } chk_t;

    chk_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] act;
    assign act = {mbc_sleep, mbc_clk_en, mbc_resetn, iso, ext_int, sleep_state};

    always @(negedge clk) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                n_cmp++;
                if (sb[i].cyc < cyc) begin
                    n_bad++;
                    $display("FAIL %s: check for cycle %0d was not reached in time (now %0d)",
                             sb[i].name, sb[i].cyc, cyc);
                end else if ((act & sb[i].mask) !== (sb[i].exp & sb[i].mask)) begin
                    n_bad++;
                    $display("FAIL %s @cycle %0d: actual %b required %b (mask %b)",
                             sb[i].name, cyc, act & sb[i].mask, sb[i].exp & sb[i].mask, sb[i].mask);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_at(input int c, input logic [5:0] v, input logic [5:0] m, input string nm);
        chk_t e;
        e.cyc  = c;
        e.exp  = v;
        e.mask = m;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic push_wake(input int k, input string nm);
        expect_at(k - 1, V_SLEEP,   MS, {nm, "_pre"});
        expect_at(k,     V_PWR_ON,  MS, {nm, "_pwr_on"});
        expect_at(k + 1, V_PWR_ON,  MS, {nm, "_pwr_on_hold"});
        expect_at(k + 2, V_CLK_ON,  MS, {nm, "_clk_on"});
        expect_at(k + 3, V_CLK_ON,  MS, {nm, "_clk_on_hold"});
        expect_at(k + 4, V_ISO_OFF, MS, {nm, "_iso_off"});
        expect_at(k + 6, V_RST_OFF, MS, {nm, "_rst_off"});
        expect_at(k + 8, V_ACTIVE,  MS, {nm, "_active"});
    endtask

    task automatic push_sleep(input int m, input string nm);
        expect_at(m - 1, V_ACTIVE,  MS, {nm, "_pre"});
        expect_at(m,     V_RST_ON,  MS, {nm, "_rst_on"});
        expect_at(m + 1, V_RST_ON,  MS, {nm, "_rst_on_hold"});
        expect_at(m + 2, V_ISO_ON,  MS, {nm, "_iso_on"});
        expect_at(m + 4, V_CLK_OFF, MS, {nm, "_clk_off"});
        expect_at(m + 6, V_PWR_OFF, MS, {nm, "_pwr_off"});
        expect_at(m + 8, V_SLEEP,   MS, {nm, "_sleep"});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m, s;
        resetn = 1'b0; wakeup_req = 1'b0; sleep_req = 1'b0; ext_int_req = 1'b0; bus_busy = 1'b0;
        tick();
        tick();
        expect_at(cyc, V_SLEEP, MA, "reset");
        resetn = 1'b1;
        expect_at(cyc + 3, V_SLEEP, MA, "idle_after_reset");
        run_to(cyc + 4);

        // Wake on bus activity
        wakeup_req = 1'b1;
        k = cyc + 1;
        push_wake(k, "wake");
        expect_at(k + 10, V_ACTIVE, MS, "wake_stay_active");
        tick();
        wakeup_req = 1'b0;
        run_to(k + 10);

        // Sleep, with a wake pulse mid-sequence
        sleep_req = 1'b1;
        m = cyc + 1;
        push_sleep(m, "sleep");
        push_wake(m + 9, "pend_wake");
        tick();
        sleep_req = 1'b0;
        run_to(m + 2);
        wakeup_req = 1'b1;
        tick();
        wakeup_req = 1'b0;
        run_to(m + 19);

        // Sleep and wake together in active, then a sleep pulse during the wake sequence
        sleep_req = 1'b1;
        wakeup_req = 1'b1;
        m = cyc + 1;
        k = m + 9;
        push_sleep(m, "both");
        push_wake(k, "both_wake");
        push_sleep(k + 9, "pend_sleep");
        expect_at(k + 19, V_SLEEP, MA, "stay_sleep");
        tick();
        sleep_req = 1'b0;
        wakeup_req = 1'b0;
        run_to(k + 2);
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        run_to(k + 19);

        // External interrupt cleared by bus busy
        ext_int_req = 1'b1;
        k = cyc + 1;
        push_wake(k, "ext_wake");
        expect_at(k,     E0, ME, "ext_not_yet");
        expect_at(k + 1, E1, ME, "ext_set");
        expect_at(k + 3, E1, ME, "ext_held");
        expect_at(k + 5, E1, ME, "ext_held_busy");
        expect_at(k + 6, E0, ME, "ext_clr_busy");
        expect_at(k + 7, E0, ME, "ext_stay_clr");
        run_to(k + 4);
        bus_busy = 1'b1;
        tick();
        bus_busy = 1'b0;
        run_to(k + 6);
        ext_int_req = 1'b0;
        run_to(k + 10);

        // Request in active is ignored
        ext_int_req = 1'b1;
        expect_at(k + 12, E0, ME, "ext_ignored_active_a");
        expect_at(k + 14, E0, ME, "ext_ignored_active_b");
        expect_at(k + 16, E0, ME, "ext_ignored_active_c");
        run_to(k + 14);
        ext_int_req = 1'b0;
        run_to(k + 16);

        sleep_req = 1'b1;
        m = cyc + 1;
        push_sleep(m, "sleep2");
        tick();
        sleep_req = 1'b0;
        run_to(m + 10);

        // External interrupt timeout, no re-arm while request stays high
        ext_int_req = 1'b1;
        k = cyc + 1;
        s = k + 1;
        push_wake(k, "to_wake");
        expect_at(k,      E0, ME, "to_not_yet");
        expect_at(s,      E1, ME, "to_set");
        expect_at(s + 8,  E1, ME, "to_mid");
        expect_at(s + 15, E1, ME, "to_last_high");
        expect_at(s + 16, E0, ME, "to_expired");
        expect_at(s + 17, E0, ME, "to_no_rearm_a");
        expect_at(s + 25, E0, ME, "to_no_rearm_b");
        run_to(s + 25);
        ext_int_req = 1'b0;
        run_to(s + 27);

        sleep_req = 1'b1;
        m = cyc + 1;
        push_sleep(m, "sleep3");
        tick();
        sleep_req = 1'b0;
        run_to(m + 10);

        // Reset in S_ISO_OFF with a sleep request pending
        wakeup_req = 1'b1;
        k = cyc + 1;
        expect_at(k,     V_PWR_ON,  MS, "rst_seq_pwr_on");
        expect_at(k + 2, V_CLK_ON,  MS, "rst_seq_clk_on");
        expect_at(k + 4, V_ISO_OFF, MS, "rst_seq_iso_off");
        expect_at(k + 5, V_SLEEP,   MA, "mid_reset");
        expect_at(k + 6, V_SLEEP,   MA, "mid_reset_release");
        expect_at(k + 12, V_SLEEP,  MA, "mid_reset_idle");
        tick();
        wakeup_req = 1'b0;
        run_to(k + 1);
        sleep_req = 1'b1;
        tick();
        sleep_req = 1'b0;
        run_to(k + 4);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        run_to(k + 12);

        wakeup_req = 1'b1;
        k = cyc + 1;
        push_wake(k, "post_reset_wake");
        expect_at(k + 12, V_ACTIVE, MS, "no_stale_sleep_pend");
        tick();
        wakeup_req = 1'b0;
        run_to(k + 13);

        repeat (3) tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d checks left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
